jellyvl_etherneco_synctimer_scheduler: RTL and testbench

JELLYVL_ETHERNECO_SYNCTIMER_SCHEDULER -- requirements
Module: jellyvl_etherneco_synctimer_scheduler

---
 rtl/jellyvl_etherneco_synctimer_scheduler.sv | 171 +++++++++++++++++
 tb/tb_jellyvl_etherneco_synctimer_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jellyvl_etherneco_synctimer_scheduler.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_synctimer_scheduler
//
// Issues periodic sync requests to the packet generator and measures the
// round-trip time of each request.
//
// Each period tick sends one request while the scheduler is idle. The
// scheduler then waits for the request to be transmitted. After that it waits
// for the returning packet, with a programmable limit on how long it waits.
// Good responses update the round-trip time. Errored or missing responses are
// counted as errors. Ticks that arrive while a transaction is still in flight
// are counted as overruns.
//
// Ports
//   reset          synchronous active-high reset
//   clk            sole clock, rising edge
//   enable         permits periodic sync issue
//   param_period   sync interval in cycles (values below 2 behave as 2)
//   param_timeout  response wait limit in cycles
//   current_time   running synctimer value
//   req_start      one-cycle command to send a sync request
//   req_time       current_time captured when the request was issued
//   tx_done        pulse: request packet fully transmitted
//   rx_end         pulse: returning packet ended
//   rx_error       qualifies rx_end as errored
//   busy           transaction in flight
//   rtt            round-trip time of the last good response
//   rtt_valid      one-cycle pulse when rtt updates
//   timeout        one-cycle pulse on response timeout
//   sync_count     good responses (saturating)
//   error_count    errored or timed-out transactions (saturating)
//   overrun_count  periods skipped because a transaction was in flight
// ---------------------------------------------------------------------------
module jellyvl_etherneco_synctimer_scheduler #(
  parameter int TIMER_WIDTH   = 64,
  parameter int PERIOD_WIDTH  = 32,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic                     enable,
  input  logic [PERIOD_WIDTH-1:0]  param_period,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  input  logic [TIMER_WIDTH-1:0]   current_time,
  output logic                     req_start,
  output logic [TIMER_WIDTH-1:0]   req_time,
  input  logic                     tx_done,
  input  logic                     rx_end,
  input  logic                     rx_error,
  output logic                     busy,
  output logic [31:0]              rtt,
  output logic                     rtt_valid,
  output logic                     timeout,
  output logic [COUNT_WIDTH-1:0]   sync_count,
  output logic [COUNT_WIDTH-1:0]   error_count,
  output logic [COUNT_WIDTH-1:0]   overrun_count
);

  localparam logic [1:0] STATE_READY     = 2'd0;
  localparam logic [1:0] STATE_SEND      = 2'd1;
  localparam logic [1:0] STATE_WAIT_RESP = 2'd2;

  logic [1:0]               state;
  logic [PERIOD_WIDTH-1:0]  period_count;
  logic [PERIOD_WIDTH-1:0]  period_last;
  logic [TIMEOUT_WIDTH-1:0] timeout_count;
  logic                     tick;

  // The statistics counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    return (value == {COUNT_WIDTH{1'b1}}) ? value : value + COUNT_WIDTH'(1);
  endfunction

  // The last counter value of a period. Periods shorter than 2 are stretched
  // to 2 so that the counter always has a distinct wrap point.
  always_comb begin
    period_last = param_period - PERIOD_WIDTH'(1);
    if (param_period < PERIOD_WIDTH'(2)) begin
      period_last = PERIOD_WIDTH'(1);
    end
  end

  assign tick = enable && (period_count == period_last);

  // Period counter. The counter can end up past the last value when
  // param_period shrinks. In that case it wraps back to 0 on the next cycle
  // without producing a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_count <= '0;
    end else if (!enable) begin
      period_count <= '0;
    end else if (period_count >= period_last) begin
      period_count <= '0;
    end else begin
      period_count <= period_count + PERIOD_WIDTH'(1);
    end
  end

  // Transaction sequencing and statistics. All pulses default low and are
  // raised only on the cycle that their event is decided. In WAIT_RESP,
  // rx_end is checked before the timeout limit, so a response that arrives
  // exactly at expiry still counts as good.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STATE_READY;
      timeout_count <= '0;
      req_start     <= 1'b0;
      req_time      <= '0;
      rtt           <= '0;
      rtt_valid     <= 1'b0;
      timeout       <= 1'b0;
      sync_count    <= '0;
      error_count   <= '0;
      overrun_count <= '0;
    end else begin
      req_start <= 1'b0;
      rtt_valid <= 1'b0;
      timeout   <= 1'b0;

      case (state)
        STATE_READY: begin
          if (tick) begin
            req_start <= 1'b1;
            req_time  <= current_time;
            state     <= STATE_SEND;
          end
        end

        STATE_SEND: begin
          if (tick) begin
            overrun_count <= sat_inc(overrun_count);
          end
          if (tx_done) begin
            timeout_count <= '0;
            state         <= STATE_WAIT_RESP;
          end
        end

        STATE_WAIT_RESP: begin
          if (tick) begin
            overrun_count <= sat_inc(overrun_count);
          end
          timeout_count <= timeout_count + TIMEOUT_WIDTH'(1);
          if (rx_end) begin
            if (!rx_error) begin
              rtt        <= current_time[31:0] - req_time[31:0];
              rtt_valid  <= 1'b1;
              sync_count <= sat_inc(sync_count);
            end else begin
              error_count <= sat_inc(error_count);
            end
            state <= STATE_READY;
          end else if (timeout_count == param_timeout) begin
            timeout     <= 1'b1;
            error_count <= sat_inc(error_count);
            state       <= STATE_READY;
          end
        end

        default: begin
          state <= STATE_READY;
        end
      endcase
    end
  end

  assign busy = (state == STATE_SEND) || (state == STATE_WAIT_RESP);

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_jellyvl_etherneco_synctimer_scheduler
//
// Self-checking bench for the sync timer scheduler. The bench keeps a
// cycle-level behavioural model of the scheduler's rules. Every output is
// compared with the model after every clock edge. Directed scenarios pin the
// model with hand-computed literal values. A randomized phase follows them.
// COUNT_WIDTH is reduced so that saturation can be reached quickly.
// ---------------------------------------------------------------------------
module tb_jellyvl_etherneco_synctimer_scheduler;

  localparam int TW  = 64;
  localparam int PW  = 16;
  localparam int TOW = 24;
  localparam int CW  = 6;
  localparam int COUNT_MAX = (1 << CW) - 1;

  logic           reset = 1'b0;
  logic           clk = 1'b0;
  logic           enable = 1'b0;
  logic [PW-1:0]  param_period = '0;
  logic [TOW-1:0] param_timeout = '0;
  logic [TW-1:0]  current_time = '0;
  logic           req_start;
  logic [TW-1:0]  req_time;
  logic           tx_done = 1'b0;
  logic           rx_end = 1'b0;
  logic           rx_error = 1'b0;
  logic           busy;
  logic [31:0]    rtt;
  logic           rtt_valid;
  logic           timeout;
  logic [CW-1:0]  sync_count;
  logic [CW-1:0]  error_count;
  logic [CW-1:0]  overrun_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: the transaction phase (0 idle, 1 awaiting tx_done,
  // 2 awaiting response), the position within the period, the elapsed
  // wait cycles, and the expected outputs.
  int          mPhase = 0;
  int          mPos = 0;
  int          mWait = 0;
  logic [63:0] mReqTime = '0;
  logic [31:0] mRtt = '0;
  bit          mReqStart = 0;
  bit          mRttValid = 0;
  bit          mTimeout = 0;
  int          mSync = 0;
  int          mErr = 0;
  int          mOver = 0;

  jellyvl_etherneco_synctimer_scheduler #(
    .TIMER_WIDTH  (TW),
    .PERIOD_WIDTH (PW),
    .TIMEOUT_WIDTH(TOW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .reset        (reset),
    .clk          (clk),
    .enable       (enable),
    .param_period (param_period),
    .param_timeout(param_timeout),
    .current_time (current_time),
    .req_start    (req_start),
    .req_time     (req_time),
    .tx_done      (tx_done),
    .rx_end       (rx_end),
    .rx_error     (rx_error),
    .busy         (busy),
    .rtt          (rtt),
    .rtt_valid    (rtt_valid),
    .timeout      (timeout),
    .sync_count   (sync_count),
    .error_count  (error_count),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  function automatic int satInc(input int v);
    return (v >= COUNT_MAX) ? COUNT_MAX : v + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Advances the model by one clock edge, using the inputs as they stand at
  // that edge.
  task automatic modelStep();
    int p;
    bit tick;
    if (reset) begin
      mPhase = 0; mPos = 0; mWait = 0; mReqTime = '0; mRtt = '0;
      mReqStart = 0; mRttValid = 0; mTimeout = 0;
      mSync = 0; mErr = 0; mOver = 0;
      return;
    end
    p = (int'(param_period) < 2) ? 2 : int'(param_period);
    tick = enable && (mPos == p - 1);
    if (!enable || mPos >= p - 1) mPos = 0;
    else mPos = mPos + 1;
    mReqStart = 0; mRttValid = 0; mTimeout = 0;
    if (mPhase == 0) begin
      if (tick) begin
        mReqStart = 1;
        mReqTime  = current_time;
        mPhase    = 1;
      end
    end else begin
      if (tick) mOver = satInc(mOver);
      if (mPhase == 1) begin
        if (tx_done) begin
          mPhase = 2;
          mWait  = 0;
        end
      end else if (rx_end) begin
        if (!rx_error) begin
          mRtt      = current_time[31:0] - mReqTime[31:0];
          mRttValid = 1;
          mSync     = satInc(mSync);
        end else begin
          mErr = satInc(mErr);
        end
        mPhase = 0;
      end else if (mWait == int'(param_timeout)) begin
        mTimeout = 1;
        mErr     = satInc(mErr);
        mPhase   = 0;
      end else begin
        mWait = mWait + 1;
      end
    end
  endtask

  // Drives one cycle of stimulus. The task then steps the model and compares
  // every output with the model shortly after the edge. Finally it advances
  // the timer by one.
  task automatic applyStimulus(input bit rst, input bit txd, input bit rxe, input bit rxerr);
    reset    = rst;
    tx_done  = txd;
    rx_end   = rxe;
    rx_error = rxerr;
    @(posedge clk);
    modelStep();
    #1;
    cyc++;
    checkOutput("req_start", 64'(req_start), 64'(mReqStart));
    checkOutput("req_time", req_time, mReqTime);
    checkOutput("busy", 64'(busy), 64'(mPhase != 0));
    checkOutput("rtt", 64'(rtt), 64'(mRtt));
    checkOutput("rtt_valid", 64'(rtt_valid), 64'(mRttValid));
    checkOutput("timeout", 64'(timeout), 64'(mTimeout));
    checkOutput("sync_count", 64'(sync_count), 64'(mSync));
    checkOutput("error_count", 64'(error_count), 64'(mErr));
    checkOutput("overrun_count", 64'(overrun_count), 64'(mOver));
    current_time = current_time + 64'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitReqStart(input int bound, output int atCycle);
    atCycle = -1;
    for (int n = 0; n < bound; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (req_start === 1'b1) begin
        atCycle = cyc;
        break;
      end
    end
    if (atCycle < 0) checkOutput("req_start_wait", 64'(req_start), 64'd1);
  endtask

  initial begin
    int a;
    int b;
    int n;

    // Reset state
    enable = 1'b1; param_period = 16'd100; param_timeout = 24'd1000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_reset_busy", 64'(busy), 64'd0);
    checkOutput("lit_reset_req_start", 64'(req_start), 64'd0);
    checkOutput("lit_reset_sync", 64'(sync_count), 64'd0);

    // Period 100; response lands 25 timer counts after the capture
    waitReqStart(200, a);
    idle(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(19);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lit_rtt_25", 64'(rtt), 64'd25);
    checkOutput("lit_rtt_valid", 64'(rtt_valid), 64'd1);
    checkOutput("lit_sync_1", 64'(sync_count), 64'd1);
    waitReqStart(200, b);
    checkOutput("lit_period_100", 64'(b - a), 64'd100);
    idle(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(19);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lit_sync_2", 64'(sync_count), 64'd2);

    // Timeout of 10 with no response
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    param_timeout = 24'd10;
    waitReqStart(200, a);
    idle(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (n < 50 && timeout !== 1'b1) begin
      idle(1);
      n++;
    end
    checkOutput("lit_timeout_delay", 64'(n), 64'd11);
    checkOutput("lit_timeout_err", 64'(error_count), 64'd1);
    waitReqStart(200, b);

    // Period 10 with a slow response: two skipped periods
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    param_period = 16'd10; param_timeout = 24'd1000;
    waitReqStart(50, a);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(24);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lit_overrun_2", 64'(overrun_count), 64'd2);
    checkOutput("lit_rtt_28", 64'(rtt), 64'd28);
    waitReqStart(50, b);
    checkOutput("lit_next_req", 64'(b - a), 64'd30);

    // rx_end coinciding with timeout expiry counts as good
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    param_period = 16'd100; param_timeout = 24'd5;
    waitReqStart(200, a);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lit_tie_sync", 64'(sync_count), 64'd1);
    checkOutput("lit_tie_err", 64'(error_count), 64'd0);
    checkOutput("lit_tie_timeout", 64'(timeout), 64'd0);
    checkOutput("lit_tie_rtt", 64'(rtt), 64'd7);

    // Errored response, then rx_end and tx_done while idle
    waitReqStart(200, a);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("lit_rxerr_err", 64'(error_count), 64'd1);
    checkOutput("lit_rxerr_rtt", 64'(rtt), 64'd7);
    checkOutput("lit_rxerr_valid", 64'(rtt_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lit_ready_sync", 64'(sync_count), 64'd1);
    checkOutput("lit_ready_busy", 64'(busy), 64'd0);

    // Timeout of 0 expires on the first wait cycle
    param_timeout = 24'd0;
    waitReqStart(200, a);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_timeout0", 64'(timeout), 64'd1);

    // Time wrap in the low 32 bits
    param_period = 16'd2; param_timeout = 24'd1000;
    current_time = 64'h0000_0000_FFFF_FFEE;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("lit_wrap_req_start", 64'(req_start), 64'd1);
    checkOutput("lit_wrap_req_time", req_time, 64'h0000_0000_FFFF_FFF0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (n < 100 && current_time[31:0] != 32'h10) begin
      idle(1);
      n++;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lit_wrap_rtt", 64'(rtt), 64'h20);

    // Reset while waiting for a response
    waitReqStart(10, a);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_rst_busy", 64'(busy), 64'd0);
    checkOutput("lit_rst_rtt", 64'(rtt), 64'd0);
    checkOutput("lit_rst_req_time", req_time, 64'd0);
    checkOutput("lit_rst_overrun", 64'(overrun_count), 64'd0);

    // Overrun counter saturates while a request never leaves SEND
    waitReqStart(10, a);
    idle(140);
    checkOutput("lit_overrun_sat", 64'(overrun_count), 64'(COUNT_MAX));
    checkOutput("lit_sat_busy", 64'(busy), 64'd1);

    // Randomized traffic
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    param_period = 16'd5; param_timeout = 24'd8; enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) param_period = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0) param_timeout = 24'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 999) == 0) current_time = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
